// File: rtl/distributor_if.sv
// distributor_if: handshake bundle between one producer, the distributor and
// OUT consumer lanes.
//   in_valid/in_ready/in_data/in_idx : single input element stream
//   out_valid/out_ready/out_data     : per-lane registered output slots
//   pos                              : one-hot lane written this cycle
//   drop                             : pulse, out-of-range element discarded
// modport master: producer/consumer side (drives inputs, observes outputs)
// modport slave : distributor side
interface distributor_if #(
  parameter int DATA = 8,
  parameter int OUT  = 4
);
  localparam int IDX_W = (OUT > 1) ? $clog2(OUT) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA-1:0]           in_data;
  logic [IDX_W-1:0]          in_idx;
  logic [OUT-1:0]            out_valid;
  logic [OUT-1:0]            out_ready;
  logic [OUT-1:0][DATA-1:0]  out_data;
  logic [OUT-1:0]            pos;
  logic                      drop;

  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, pos, drop
  );

  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, pos, drop
  );
endinterface

// File: rtl/distributor.sv
// distributor: fans one input element stream out to OUT one-entry lane slots.
//   MODE=0 : destination taken from in_idx; out-of-range indices are accepted,
//            discarded and flagged by a registered drop pulse.
//   MODE=1 : destination is the first free lane (lowest when MSB=0, highest
//            when MSB=1); in_idx is ignored.
// Ports: clk, reset (sync, active high), bus (distributor_if.slave).
// A lane draining in the same cycle counts as free, so a full lane can be
// reloaded without a bubble. At most one lane is written per cycle.

// One output slot: registered valid + data, reload wins over drain.
module distributor_lane #(
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DATA-1:0] wr_data,
  input  logic            rdy,
  output logic            valid,
  output logic [DATA-1:0] data
);
  logic            valid_d, valid_q;
  logic [DATA-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (wr) begin
      valid_d = 1'b1;
      data_d  = wr_data;
    end else if (valid_q && rdy) begin
      // data is left as-is on drain; only valid falls
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

module distributor #(
  parameter int MODE = 0,
  parameter int DATA = 8,
  parameter int OUT  = 4,
  parameter int MSB  = 0
) (
  input  logic          clk,
  input  logic          reset,
  distributor_if.slave  bus
);
  localparam int IDX_W = (OUT > 1) ? $clog2(OUT) : 1;

  logic [OUT-1:0]   free;
  logic [OUT-1:0]   wr;
  logic [IDX_W-1:0] tgt;
  logic             in_range;
  logic             fire;
  logic             drop_d, drop_q;

  assign free = ~bus.out_valid | bus.out_ready;

  // Target selection and in_ready. in_ready never looks at in_valid.
  always_comb begin
    tgt          = '0;
    in_range     = 1'b0;
    bus.in_ready = 1'b0;
    if (MODE == 0) begin
      tgt = bus.in_idx;
      // match by compare so a non-power-of-two OUT never indexes past free
      for (int i = 0; i < OUT; i++) begin
        if (bus.in_idx == IDX_W'(i)) begin
          in_range     = 1'b1;
          bus.in_ready = free[i];
        end
      end
      // out-of-range elements are swallowed so the producer never stalls
      if (!in_range) bus.in_ready = 1'b1;
    end else begin
      // scan so the winning lane is the last one assigned
      if (MSB == 0) begin
        for (int i = OUT - 1; i >= 0; i--) begin
          if (free[i]) begin
            tgt      = IDX_W'(i);
            in_range = 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < OUT; i++) begin
          if (free[i]) begin
            tgt      = IDX_W'(i);
            in_range = 1'b1;
          end
        end
      end
      bus.in_ready = |free;
    end
  end

  always_comb begin
    fire   = bus.in_valid & bus.in_ready & in_range;
    wr     = fire ? (OUT'(1) << tgt) : '0;
    drop_d = (MODE == 0) & bus.in_valid & ~in_range;
  end

  assign bus.pos = wr;

  always_ff @(posedge clk) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= drop_d;
  end

  assign bus.drop = drop_q;

  for (genvar g = 0; g < OUT; g++) begin : g_lane
    distributor_lane #(.DATA(DATA)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[g]),
      .wr_data (bus.in_data),
      .rdy     (bus.out_ready[g]),
      .valid   (bus.out_valid[g]),
      .data    (bus.out_data[g])
    );
  end
endmodule

// File: tb/tb_distributor.sv
// Four distributor instances share one stimulus stream:
//   u0 MODE=0 OUT=4, u1 MODE=0 OUT=3, u2 MODE=1 MSB=0 OUT=4, u3 MODE=1 MSB=1 OUT=4.
// An array-based model of the slot rules is stepped every cycle and compared
// against all four; directed scenarios add literal expectations.
module tb_distributor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       s_valid;
  logic [7:0] s_data;
  logic [1:0] s_idx;
  logic [3:0] s_rdy;

  distributor_if #(.DATA(8), .OUT(4)) ia ();
  distributor_if #(.DATA(8), .OUT(3)) ib ();
  distributor_if #(.DATA(8), .OUT(4)) ic ();
  distributor_if #(.DATA(8), .OUT(4)) id ();

  assign ia.in_valid = s_valid; assign ia.in_data = s_data; assign ia.in_idx = s_idx; assign ia.out_ready = s_rdy;
  assign ib.in_valid = s_valid; assign ib.in_data = s_data; assign ib.in_idx = s_idx; assign ib.out_ready = s_rdy[2:0];
  assign ic.in_valid = s_valid; assign ic.in_data = s_data; assign ic.in_idx = s_idx; assign ic.out_ready = s_rdy;
  assign id.in_valid = s_valid; assign id.in_data = s_data; assign id.in_idx = s_idx; assign id.out_ready = s_rdy;

  distributor #(.MODE(0), .DATA(8), .OUT(4), .MSB(0)) u0 (.clk(clk), .reset(reset), .bus(ia));
  distributor #(.MODE(0), .DATA(8), .OUT(3), .MSB(0)) u1 (.clk(clk), .reset(reset), .bus(ib));
  distributor #(.MODE(1), .DATA(8), .OUT(4), .MSB(0)) u2 (.clk(clk), .reset(reset), .bus(ic));
  distributor #(.MODE(1), .DATA(8), .OUT(4), .MSB(1)) u3 (.clk(clk), .reset(reset), .bus(id));

  // uniform views of the four instances (u1 padded to 4 lanes)
  logic        d_ready [4];
  logic [3:0]  d_pos   [4];
  logic [3:0]  d_vld   [4];
  logic [31:0] d_data  [4];
  logic        d_drop  [4];

  assign d_ready[0] = ia.in_ready; assign d_pos[0] = ia.pos; assign d_vld[0] = ia.out_valid;
  assign d_data[0]  = ia.out_data; assign d_drop[0] = ia.drop;
  assign d_ready[1] = ib.in_ready; assign d_pos[1] = {1'b0, ib.pos}; assign d_vld[1] = {1'b0, ib.out_valid};
  assign d_data[1]  = {8'h00, ib.out_data}; assign d_drop[1] = ib.drop;
  assign d_ready[2] = ic.in_ready; assign d_pos[2] = ic.pos; assign d_vld[2] = ic.out_valid;
  assign d_data[2]  = ic.out_data; assign d_drop[2] = ic.drop;
  assign d_ready[3] = id.in_ready; assign d_pos[3] = id.pos; assign d_vld[3] = id.out_valid;
  assign d_data[3]  = id.out_data; assign d_drop[3] = id.drop;

  int cfg_mode [4] = '{0, 0, 1, 1};
  int cfg_out  [4] = '{4, 3, 4, 4};
  int cfg_msb  [4] = '{0, 0, 0, 1};

  // model state: slot occupancy, slot contents, pending drop pulse
  bit         mv    [4][4];
  logic [7:0] md    [4][4];
  bit         mdrop [4];

  bit chk_en  = 1'b0;
  bit cons_en = 1'b0;
  int n_fire [4], n_drain [4], n_bad [4], n_dropseen [4];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      mdrop[k] = 1'b0;
      n_fire[k] = 0; n_drain[k] = 0; n_bad[k] = 0; n_dropseen[k] = 0;
      for (int i = 0; i < 4; i++) begin mv[k][i] = 1'b0; md[k][i] = 8'h00; end
    end
  end

  // compare + model step, once per cycle on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      automatic int n = cfg_out[k];
      automatic int tgt = -1;
      automatic bit rng = 1'b0;
      automatic bit rdy = 1'b0;
      automatic bit fire, bad;
      automatic logic [3:0]  epos = 4'b0000;
      automatic logic [3:0]  evld = 4'b0000;
      automatic logic [31:0] edat = 32'h0;

      if (cfg_mode[k] == 0) begin
        if (int'(s_idx) < n) begin
          tgt = int'(s_idx);
          rng = 1'b1;
          rdy = !mv[k][tgt] || s_rdy[tgt];
        end else begin
          rdy = 1'b1;
        end
      end else begin
        for (int j = 0; j < n; j++) begin
          automatic int i = (cfg_msb[k] == 0) ? j : n - 1 - j;
          if (tgt < 0 && (!mv[k][i] || s_rdy[i])) tgt = i;
        end
        rng = (tgt >= 0);
        rdy = rng;
      end
      fire = s_valid && rdy && rng;
      bad  = (cfg_mode[k] == 0) && s_valid && !rng;
      if (fire) epos = 4'(1 << tgt);
      for (int i = 0; i < 4; i++) begin
        evld[i] = mv[k][i];
        edat[i*8 +: 8] = md[k][i];
      end

      if (chk_en) begin
        chk($sformatf("u%0d.in_ready", k), 32'(d_ready[k]), 32'(rdy));
        chk($sformatf("u%0d.pos", k), 32'(d_pos[k]), 32'(epos));
        chk($sformatf("u%0d.out_valid", k), 32'(d_vld[k]), 32'(evld));
        chk($sformatf("u%0d.out_data", k), d_data[k], edat);
        chk($sformatf("u%0d.drop", k), 32'(d_drop[k]), 32'(mdrop[k]));
      end

      if (cons_en && !reset) begin
        n_fire[k] += int'(fire);
        n_bad[k]  += int'(bad);
        n_dropseen[k] += int'(d_drop[k]);
        for (int i = 0; i < n; i++) n_drain[k] += int'(d_vld[k][i] && s_rdy[i]);
      end

      if (reset) begin
        mdrop[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin mv[k][i] = 1'b0; md[k][i] = 8'h00; end
      end else begin
        for (int i = 0; i < n; i++) if (mv[k][i] && s_rdy[i]) mv[k][i] = 1'b0;
        if (fire) begin
          mv[k][tgt] = 1'b1;
          md[k][tgt] = s_data;
        end
        mdrop[k] = bad;
      end
    end
  end

  task automatic drive(bit v, logic [7:0] d, logic [1:0] i, logic [3:0] r);
    s_valid = v; s_data = d; s_idx = i; s_rdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 2'd0, 4'b0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, 8'h00, 2'd0, 4'b0000);
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset.out_valid", 32'(d_vld[0]), 32'h0);
    chk("reset.out_data", d_data[0], 32'h0);
    chk("reset.drop", 32'(d_drop[0]), 32'h0);

    // explicit index routing with backpressure
    drive(1'b1, 8'hA1, 2'd2, 4'b0000); tick();
    drive(1'b1, 8'hB2, 2'd0, 4'b0000); tick();
    chk("route.out_valid", 32'(d_vld[0]), 32'h5);
    chk("route.lane2", 32'(d_data[0][23:16]), 32'hA1);
    chk("route.lane0", 32'(d_data[0][7:0]), 32'hB2);
    drive(1'b1, 8'hC3, 2'd2, 4'b0000); #1;
    chk("route.blocked_ready", 32'(d_ready[0]), 32'h0);
    tick();
    chk("route.held_lane2", 32'(d_data[0][23:16]), 32'hA1);
    drive(1'b1, 8'hC3, 2'd2, 4'b0100); #1;
    chk("route.unblocked_ready", 32'(d_ready[0]), 32'h1);
    chk("route.pos", 32'(d_pos[0]), 32'h4);
    tick();
    chk("route.reload_lane2", 32'(d_data[0][23:16]), 32'hC3);
    chk("route.reload_valid", 32'(d_vld[0]), 32'h5);

    // out-of-range index on OUT=3, back-to-back
    do_reset();
    drive(1'b1, 8'h66, 2'd3, 4'b0000); #1;
    chk("oor.in_ready", 32'(d_ready[1]), 32'h1);
    chk("oor.pos", 32'(d_pos[1]), 32'h0);
    tick();
    chk("oor.drop1", 32'(d_drop[1]), 32'h1);
    chk("oor.no_write", 32'(d_vld[1]), 32'h0);
    drive(1'b1, 8'h67, 2'd3, 4'b0000); tick();
    chk("oor.drop2", 32'(d_drop[1]), 32'h1);
    drive(1'b0, 8'h00, 2'd0, 4'b0000); tick();
    chk("oor.drop_end", 32'(d_drop[1]), 32'h0);

    // priority fill, both directions
    do_reset();
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 8'(8'h10 + b), 2'd0, 4'b0000); #1;
      chk($sformatf("prio_lo.pos%0d", b), 32'(d_pos[2]), 32'(1 << b));
      chk($sformatf("prio_hi.pos%0d", b), 32'(d_pos[3]), 32'(8 >> b));
      tick();
    end
    drive(1'b1, 8'h14, 2'd0, 4'b0000); #1;
    chk("prio_lo.full_ready", 32'(d_ready[2]), 32'h0);
    chk("prio_hi.full_ready", 32'(d_ready[3]), 32'h0);
    chk("prio_lo.data", d_data[2], 32'h13121110);
    chk("prio_hi.data", d_data[3], 32'h10111213);
    tick();

    // same-cycle drain and fill on a full instance
    drive(1'b1, 8'h55, 2'd0, 4'b0100); #1;
    chk("refill.in_ready", 32'(d_ready[2]), 32'h1);
    chk("refill.pos", 32'(d_pos[2]), 32'h4);
    tick();
    chk("refill.out_valid", 32'(d_vld[2]), 32'hF);
    chk("refill.lane2", 32'(d_data[2][23:16]), 32'h55);

    // lane 1 held under backpressure while others move
    for (int c = 0; c < 10; c++) begin
      drive(1'($urandom), 8'($urandom), 2'($urandom), 4'($urandom) & 4'b1101);
      tick();
      chk("hold.lane1_data", 32'(d_data[2][15:8]), 32'h11);
      chk("hold.lane1_valid", 32'(d_vld[2][1]), 32'h1);
    end

    // reset mid-stream: refill, then reset with a beat presented
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 8'(8'h20 + b), 2'd0, 4'b0000); tick();
    end
    reset = 1'b1;
    drive(1'b1, 8'h77, 2'd1, 4'b0000);
    tick();
    reset = 1'b0;
    drive(1'b0, 8'h00, 2'd0, 4'b0000);
    chk("midrst.out_valid", 32'(d_vld[2]), 32'h0);
    chk("midrst.out_data", d_data[2], 32'h0);
    chk("midrst.drop", 32'(d_drop[0]), 32'h0);
    tick();
    chk("midrst.not_stored", 32'(d_vld[2]), 32'h0);

    // random traffic with conservation accounting
    cons_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 4'($urandom));
      tick();
    end
    cons_en = 1'b0;
    drive(1'b0, 8'h00, 2'd0, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d.conserve", k), 32'(n_drain[k] + $countones(d_vld[k])), 32'(n_fire[k]));
      chk($sformatf("u%0d.drop_count", k), 32'(n_dropseen[k] + int'(d_drop[k])), 32'(n_bad[k]));
    end
    chk("u1.saw_drops", 32'(n_bad[1] > 0), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/distributor.md
Name: distributor

Overview:
- Inverse of the parameterised N:1 selector: takes one input element stream and dispatches each accepted element to exactly one of OUT output lanes.
- Each lane has a one-entry registered output slot with a valid/ready handshake.
- Destination is either an explicit index (MODE=0) or the first free lane by priority (MODE=1).
- Used to fan a single producer out to parallel consumers, e.g. issue slots or worker pipes.

Parameters:
- MODE, 0, destination rule: 0 = explicit index from in_idx, 1 = first free lane by priority
- DATA, 8, width of one element
- OUT, 4, number of output lanes, at least 1
- MSB, 0, MODE=1 only: 0 = lowest free lane wins, 1 = highest free lane wins
- IDX_W, max($clog2(OUT),1), width of in_idx and lane-index fields (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input element present
- in_ready  out  1  input element accepted this cycle when in_valid is also high (combinational)
- in_data  in  DATA  input element
- in_idx  in  IDX_W  destination lane; used only when MODE=0, ignored when MODE=1
- out_valid  out  OUT  per-lane slot occupied (registered)
- out_ready  in  OUT  per-lane consumer accepts
- out_data  out  OUT*DATA  per-lane slot contents, packed [OUT-1:0][DATA-1:0] (registered)
- pos  out  OUT  one-hot lane written this cycle; all zero if nothing is written (combinational)
- drop  out  1  registered pulse: an element with an out-of-range index was discarded last cycle

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, drop=0. Reset dominates any handshake in the same cycle.
- Lane free condition: free[i] = !out_valid[i] || out_ready[i]. A slot draining this cycle counts as free, so full throughput is kept.
- Target selection, MODE=0:
  - tgt = in_idx.
  - If in_idx >= OUT: in_ready=1, the element is discarded, no lane is written, pos=0, and drop=1 on the next cycle.
  - Otherwise in_ready = free[in_idx].
- Target selection, MODE=1:
  - tgt = lowest-index free lane (MSB=0) or highest-index free lane (MSB=1).
  - in_ready = |free. in_idx is ignored.
- Accept: fire = in_valid && in_ready && target in range.
  - On fire: out_valid[tgt] <= 1 and out_data[tgt] <= in_data.
  - pos = one-hot(tgt) when fire, else 0.
- Drain: when out_valid[i] && out_ready[i] and lane i is not written this cycle, out_valid[i] <= 0 and out_data[i] holds its value.
- Simultaneous drain and fill of the same lane: slot is reloaded with the new element and out_valid stays 1. There is no bubble.
- Latency: an element appears on out_data[tgt] with out_valid set 1 cycle after acceptance.
- Per-lane stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] and out_valid[i] must not change.
- Ordering: at most one lane is written per cycle.
- Other lanes drain independently in the same cycle as any fill.
- Combinational paths: in_ready may depend combinationally on out_ready and in_idx. It must not depend on in_valid.
- in_valid low: no state change other than drains; pos=0.
- OUT=1: in_idx is ignored except for the range check (in_idx != 0 drops in MODE=0). Behaves as a single-entry pipeline register.
- drop is a single-cycle pulse per discarded element. Back-to-back bad indices give consecutive drop=1 cycles.

Test Plan:
- Reset mid-stream: fill lanes 0..3, assert reset for 1 cycle -> next cycle out_valid=4'b0000, out_data all 0, drop=0; the in_valid beat during reset is not stored.
- MODE=0 index routing: send 0xA1 idx=2, then 0xB2 idx=0, out_ready=0 -> out_valid=4'b0101, out_data[2]=0xA1, out_data[0]=0xB2; a further beat with idx=2 sees in_ready=0 until out_ready[2]=1.
- MODE=0 out-of-range with OUT=3: in_idx=3, in_valid=1 -> in_ready=1, pos=0, no lane written, drop=1 on the following cycle only.
- MODE=1 priority fill, MSB=0: four beats 0x10..0x13 with out_ready=0 -> lanes 0,1,2,3 filled in order, pos=0001,0010,0100,1000; fifth beat sees in_ready=0. Same test with MSB=1 -> lanes filled 3,2,1,0.
- Same-cycle drain and fill, MODE=1, all lanes full: out_ready=4'b0100 with in_valid=1, data 0x55 -> in_ready=1, pos=4'b0100, out_valid stays 4'b1111, out_data[2]=0x55 next cycle.
- Backpressure stability: hold out_ready[1]=0 for 10 cycles while lane 1 is valid -> out_data[1] constant; random in_valid/out_ready traffic over 10k cycles -> scoreboard sees no loss or duplication, and no dropped element other than those flagged by drop.
